// File: rtl/uart_pkg.sv
// Shared UART framing constants, parser states and the FIFO beat layout.
package uart_pkg;
  localparam logic [7:0] UART_SOF = 8'hA5;

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHECK} deframe_state_t;

  typedef struct packed {
    logic       user;
    logic       last;
    logic [7:0] data;
  } axis_beat_t;
endpackage

// File: rtl/axis_sync_fifo.sv
// First-word fall-through sync FIFO: a push shows on the read side 1 cycle later.
// When full, a push is taken only alongside a pop; otherwise the caller sees full and drops it.
module axis_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             push_acc;
  logic             pop_acc;

  // Pointers carry one extra bit so full and empty stay distinguishable.
  assign count    = wptr - rptr;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (wptr == rptr);
  assign pop_acc  = pop && !empty;
  assign push_acc = push && (!full || pop_acc);
  assign pop_dat  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_acc) wptr <= wptr + 1'b1;
      if (pop_acc)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wptr[AW-1:0]] <= push_dat;
  end
endmodule

// File: rtl/uart_rx_deframer.sv
// Extracts SOF/LEN/payload/XOR-checked frames from a valid-only byte stream onto AXI-Stream.
// Beats appear 1 cycle after FIFO push; on a stalled m_axis the FIFO fills, then bytes drop and set overflow.
module uart_rx_deframer #(
  parameter int DEPTH        = 16,
  parameter int TIMEOUT_CLKS = 8680
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       overflow,
  input  logic       overflow_clr
);
  import uart_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);

  deframe_state_t         state, state_nxt;
  logic [7:0]             csum, csum_nxt;
  logic [7:0]             rem, rem_nxt;
  logic                   hold_vld, hold_vld_nxt;
  logic [7:0]             hold_dat, hold_dat_nxt;
  logic [TW-1:0]          timer;
  logic                   timeout;
  logic                   chk_bad;
  logic                   frame_ok_nxt, frame_err_nxt;
  logic                   push, pop, drop;
  axis_beat_t             push_beat, pop_beat, out_beat;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  assign timeout = (state != HUNT) && (timer == TIMER_LAST);
  assign chk_bad = (s_axis_tdata != csum);

  always_comb begin
    state_nxt     = state;
    csum_nxt      = csum;
    rem_nxt       = rem;
    hold_vld_nxt  = hold_vld;
    hold_dat_nxt  = hold_dat;
    push          = 1'b0;
    push_beat     = '0;
    frame_ok_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    if (timeout) begin
      // Abort flushes the held byte as a bad tail; a coincident byte is re-read as a HUNT byte.
      push          = hold_vld;
      push_beat     = '{user: 1'b1, last: 1'b1, data: hold_dat};
      hold_vld_nxt  = 1'b0;
      frame_err_nxt = 1'b1;
      state_nxt     = (s_axis_tvalid && s_axis_tdata == UART_SOF) ? LEN : HUNT;
    end else if (s_axis_tvalid) begin
      case (state)
        HUNT: if (s_axis_tdata == UART_SOF) state_nxt = LEN;
        LEN: begin
          csum_nxt  = s_axis_tdata;
          rem_nxt   = s_axis_tdata;
          state_nxt = (s_axis_tdata == 8'd0) ? CHECK : PAYLOAD;
        end
        PAYLOAD: begin
          // The newest byte waits in hold until we know whether it is the frame's last.
          csum_nxt     = csum ^ s_axis_tdata;
          rem_nxt      = rem - 8'd1;
          push         = hold_vld;
          push_beat    = '{user: 1'b0, last: 1'b0, data: hold_dat};
          hold_vld_nxt = 1'b1;
          hold_dat_nxt = s_axis_tdata;
          if (rem == 8'd1) state_nxt = CHECK;
        end
        CHECK: begin
          push          = hold_vld;
          push_beat     = '{user: chk_bad, last: 1'b1, data: hold_dat};
          hold_vld_nxt  = 1'b0;
          frame_ok_nxt  = !chk_bad;
          frame_err_nxt = chk_bad;
          state_nxt     = HUNT;
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      csum      <= '0;
      rem       <= '0;
      hold_vld  <= 1'b0;
      hold_dat  <= '0;
      timer     <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      csum      <= csum_nxt;
      rem       <= rem_nxt;
      hold_vld  <= hold_vld_nxt;
      hold_dat  <= hold_dat_nxt;
      frame_ok  <= frame_ok_nxt;
      frame_err <= frame_err_nxt;
      if (s_axis_tvalid || state == HUNT || timeout) timer <= '0;
      else                                           timer <= timer + 1'b1;
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  assign pop  = m_axis_tvalid && m_axis_tready;
  assign drop = push && fifo_full && !pop;

  axis_sync_fifo #(.WIDTH(10), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_beat),
    .full     (fifo_full),
    .pop      (pop),
    .pop_dat  (pop_beat),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign out_beat      = fifo_empty ? '0 : pop_beat;
  assign m_axis_tdata  = out_beat.data;
  assign m_axis_tlast  = out_beat.last;
  assign m_axis_tuser  = out_beat.user;

  a_fifo_count: assert property (@(posedge clk) disable iff (rst) int'(fifo_count) <= DEPTH);
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed frame table, timeout/overflow/reset sequences and a randomized stream vs. a frame-level model.
module tb_uart_rx_deframer;
  localparam int DEPTH = 16;
  localparam int TO    = 8680;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       frame_ok;
  logic       frame_err;
  logic       overflow;
  logic       overflow_clr = 1'b0;

  uart_rx_deframer #(.DEPTH(DEPTH), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .frame_ok(frame_ok), .frame_err(frame_err),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_mis = 0;
  logic [9:0] beat_q[$];
  int         ok_cnt = 0;
  int         err_cnt = 0;
  int         rdy_mode = 1;
  logic [9:0] exp_q[$];
  int         exp_ok;
  int         exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Ready driver: 0 = stall, 1 = always ready, 2 = random 75%.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = ($urandom_range(3) != 0);
      endcase
    end
  end

  // Monitor: collects accepted beats, counts pulses, checks stall stability.
  logic       prev_stall = 1'b0;
  logic [9:0] prev_beat = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold_stable", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {1'b1, prev_beat});
      if (m_axis_tvalid && m_axis_tready) beat_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      if (frame_ok)  ok_cnt++;
      if (frame_err) err_cnt++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    tick(1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bs[$], input int gap);
    for (int i = 0; i < bs.size(); i++) begin
      send_byte(bs[i]);
      tick(gap);
    end
  endtask

  task automatic clear_obs();
    beat_q.delete();
    ok_cnt  = 0;
    err_cnt = 0;
  endtask

  // Frame-level reference: scan for SOF, slice LEN bytes, XOR-check, emit beats.
  task automatic run_model(input logic [7:0] bs[$]);
    int i;
    exp_q.delete();
    exp_ok  = 0;
    exp_err = 0;
    i = 0;
    while (i < bs.size()) begin
      if (bs[i] == 8'hA5 && i + 1 < bs.size() && i + 2 + int'(bs[i+1]) < bs.size()) begin
        int         len;
        logic [7:0] x;
        logic       bad;
        len = int'(bs[i+1]);
        x   = bs[i+1];
        for (int k = 0; k < len; k++) x ^= bs[i+2+k];
        bad = (x != bs[i+2+len]);
        for (int k = 0; k < len; k++)
          exp_q.push_back({bad && (k == len-1), k == len-1, bs[i+2+k]});
        if (bad) exp_err++;
        else     exp_ok++;
        i += len + 3;
      end else begin
        i++;
      end
    end
  endtask

  typedef struct {
    string      name;
    int         n_in;
    logic [7:0] in_b[8];
    int         n_exp;
    logic [7:0] exp_dat[4];
    logic       exp_user;
    int         exp_ok;
    int         exp_err;
  } dvec_t;

  dvec_t tbl[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] bs[$];
    logic [7:0] x;
    int         k;

    tbl[0] = '{name:"good3", n_in:6, in_b:'{8'hA5,8'h03,8'h11,8'h22,8'h33,8'h03,8'h00,8'h00},
               n_exp:3, exp_dat:'{8'h11,8'h22,8'h33,8'h00}, exp_user:1'b0, exp_ok:1, exp_err:0};
    tbl[1] = '{name:"badchk", n_in:6, in_b:'{8'hA5,8'h03,8'h11,8'h22,8'h33,8'h04,8'h00,8'h00},
               n_exp:3, exp_dat:'{8'h11,8'h22,8'h33,8'h00}, exp_user:1'b1, exp_ok:0, exp_err:1};
    tbl[2] = '{name:"noise_len0", n_in:6, in_b:'{8'h00,8'hFF,8'h5A,8'hA5,8'h00,8'h00,8'h00,8'h00},
               n_exp:0, exp_dat:'{8'h00,8'h00,8'h00,8'h00}, exp_user:1'b0, exp_ok:1, exp_err:0};
    tbl[3] = '{name:"one_byte", n_in:4, in_b:'{8'hA5,8'h01,8'h7E,8'h7F,8'h00,8'h00,8'h00,8'h00},
               n_exp:1, exp_dat:'{8'h7E,8'h00,8'h00,8'h00}, exp_user:1'b0, exp_ok:1, exp_err:0};
    tbl[4] = '{name:"two_byte", n_in:5, in_b:'{8'hA5,8'h02,8'hAB,8'hCD,8'h64,8'h00,8'h00,8'h00},
               n_exp:2, exp_dat:'{8'hAB,8'hCD,8'h00,8'h00}, exp_user:1'b0, exp_ok:1, exp_err:0};
    tbl[5] = '{name:"len0_bad", n_in:3, in_b:'{8'hA5,8'h00,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00},
               n_exp:0, exp_dat:'{8'h00,8'h00,8'h00,8'h00}, exp_user:1'b0, exp_ok:0, exp_err:1};

    // Reset state
    tick(3);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, 0);
    check("rst_pulses", {frame_ok, frame_err}, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    tick(2);

    // Directed frame table
    foreach (tbl[v]) begin
      clear_obs();
      for (int j = 0; j < tbl[v].n_in; j++) begin
        send_byte(tbl[v].in_b[j]);
        tick(1);
      end
      tick(6);
      check($sformatf("%s_nbeats", tbl[v].name), beat_q.size(), tbl[v].n_exp);
      for (int j = 0; j < tbl[v].n_exp && j < beat_q.size(); j++) begin
        check($sformatf("%s_dat%0d", tbl[v].name, j), beat_q[j][7:0], tbl[v].exp_dat[j]);
        check($sformatf("%s_last%0d", tbl[v].name, j), beat_q[j][8], j == tbl[v].n_exp - 1);
        check($sformatf("%s_user%0d", tbl[v].name, j), beat_q[j][9],
              (j == tbl[v].n_exp - 1) ? tbl[v].exp_user : 1'b0);
      end
      check($sformatf("%s_ok", tbl[v].name), ok_cnt, tbl[v].exp_ok);
      check($sformatf("%s_err", tbl[v].name), err_cnt, tbl[v].exp_err);
    end

    // Timeout abort mid-payload, then a good frame
    clear_obs();
    send_byte(8'hA5); tick(1);
    send_byte(8'h02); tick(1);
    send_byte(8'h55);
    k = 0;
    while (!m_axis_tvalid && k < TO + 100) begin
      tick(1);
      k++;
    end
    check("timeout_latency", k, TO);
    tick(4);
    check("timeout_nbeats", beat_q.size(), 1);
    if (beat_q.size() > 0) check("timeout_beat", beat_q[0], {2'b11, 8'h55});
    check("timeout_err", err_cnt, 1);
    check("timeout_ok", ok_cnt, 0);
    clear_obs();
    bs = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_bytes(bs, 1);
    tick(6);
    check("post_to_nbeats", beat_q.size(), 1);
    if (beat_q.size() > 0) check("post_to_beat", beat_q[0], {2'b01, 8'h7E});
    check("post_to_ok", ok_cnt, 1);

    // SOF arriving in the very cycle the timeout fires still opens a new frame
    clear_obs();
    send_byte(8'hA5); tick(1);
    send_byte(8'h02); tick(1);
    send_byte(8'h55);
    tick(TO - 1);
    send_byte(8'hA5); tick(1);
    bs = '{8'h01, 8'h7E, 8'h7F};
    send_bytes(bs, 1);
    tick(6);
    check("collide_nbeats", beat_q.size(), 2);
    if (beat_q.size() > 1) begin
      check("collide_beat0", beat_q[0], {2'b11, 8'h55});
      check("collide_beat1", beat_q[1], {2'b01, 8'h7E});
    end
    check("collide_ok", ok_cnt, 1);
    check("collide_err", err_cnt, 1);

    // Overflow: LEN=20 into a stalled 16-deep FIFO
    rdy_mode = 0;
    tick(2);
    clear_obs();
    x = 8'd20;
    bs = '{8'hA5, 8'd20};
    for (int i = 0; i < 20; i++) begin
      bs.push_back(8'h30 + 8'(i));
      x ^= 8'h30 + 8'(i);
    end
    bs.push_back(x);
    send_bytes(bs, 1);
    tick(4);
    check("ovf_tvalid", m_axis_tvalid, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_ok", ok_cnt, 1);
    check("ovf_err", err_cnt, 0);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    rdy_mode = 1;
    tick(30);
    check("ovf_nbeats", beat_q.size(), 16);
    for (int i = 0; i < 16 && i < beat_q.size(); i++)
      check($sformatf("ovf_beat%0d", i), beat_q[i], {2'b00, 8'h30 + 8'(i)});
    check("ovf_drained", m_axis_tvalid, 0);

    // Reset mid-payload with 3 beats queued
    rdy_mode = 0;
    tick(2);
    clear_obs();
    bs = '{8'hA5, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04};
    send_bytes(bs, 1);
    tick(2);
    check("mrst_pre_tvalid", m_axis_tvalid, 1);
    rst = 1'b1;
    tick(1);
    check("mrst_tvalid", m_axis_tvalid, 0);
    rst = 1'b0;
    rdy_mode = 1;
    tick(6);
    check("mrst_pulses", ok_cnt + err_cnt, 0);
    check("mrst_nbeats", beat_q.size(), 0);
    bs = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_bytes(bs, 1);
    tick(6);
    check("mrst_next_nbeats", beat_q.size(), 1);
    if (beat_q.size() > 0) check("mrst_next_beat", beat_q[0], {2'b01, 8'h7E});
    check("mrst_next_ok", ok_cnt, 1);
    check("mrst_next_err", err_cnt, 0);

    // Randomized stream with random backpressure
    clear_obs();
    rdy_mode = 2;
    bs.delete();
    for (int f = 0; f < 40; f++) begin
      int         nn;
      int         len;
      logic [7:0] b;
      nn = $urandom_range(3);
      for (int i = 0; i < nn; i++) begin
        b = 8'($urandom_range(255));
        bs.push_back((b == 8'hA5) ? 8'h00 : b);
      end
      len = $urandom_range(12);
      bs.push_back(8'hA5);
      bs.push_back(8'(len));
      x = 8'(len);
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom_range(255));
        bs.push_back(b);
        x ^= b;
      end
      if ($urandom_range(3) == 0) x ^= 8'($urandom_range(255, 1));
      bs.push_back(x);
    end
    for (int i = 0; i < bs.size(); i++) begin
      send_byte(bs[i]);
      tick($urandom_range(4, 2));
    end
    tick(40);
    rdy_mode = 1;
    tick(40);
    run_model(bs);
    check("rand_nbeats", beat_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++)
      check($sformatf("rand_beat%0d", i), beat_q[i], exp_q[i]);
    check("rand_ok", ok_cnt, exp_ok);
    check("rand_err", err_cnt, exp_err);
    check("rand_overflow", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
